// File: rtl/mips_pkg.sv
// mips_pkg: types and constants shared by the instruction-fetch blocks.
//   fetch_state_e  - fetch sequencer states
//   fetch_entry_t  - one fetched instruction plus its byte address
//   PC_STEP        - byte increment between consecutive 16-bit instructions
package mips_pkg;

    localparam int          PC_W           = 16;
    localparam int          DATA_W         = 16;
    localparam int          PC_STEP        = 2;
    localparam logic [15:0] HALT_INSTR_DEF = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        END  = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: fetch-side buses.
//   imem_pc / imem_instr          - combinational ROM lookup
//   ifid_valid/ready/instr/pc     - valid/ready handshake toward decode
// master = fetch sequencer, slave = ROM + decode side.
interface fetch_ctrl_if #(
    parameter int PC_WIDTH  = 16,
    parameter int DATA_SIZE = 16
);
    logic [PC_WIDTH-1:0]  imem_pc;
    logic [DATA_SIZE-1:0] imem_instr;
    logic                 ifid_valid;
    logic                 ifid_ready;
    logic [DATA_SIZE-1:0] ifid_instr;
    logic [PC_WIDTH-1:0]  ifid_pc;

    modport master (
        output imem_pc,
        input  imem_instr,
        output ifid_valid,
        input  ifid_ready,
        output ifid_instr,
        output ifid_pc
    );

    modport slave (
        input  imem_pc,
        output imem_instr,
        input  ifid_valid,
        output ifid_ready,
        input  ifid_instr,
        input  ifid_pc
    );
endinterface

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: 2-entry FIFO of fetch_entry_t between fetch and decode.
//   clk, rst     - clock, async active-high reset
//   push_i/din_i - write din_i at the tail (caller guarantees space)
//   pop_i        - consume the head (ignored when empty)
//   flush_i      - drop all entries; wins over push/pop
//   count_o      - occupancy 0..2
//   valid_o      - head is valid
//   head_o       - head entry
// Entry 0 is always the head, so outputs come straight from a register.
module fetch_skid_fifo
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  fetch_entry_t din_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   count_o,
    output logic         valid_o,
    output fetch_entry_t head_o
);

    fetch_entry_t e0_q, e0_d, e1_q, e1_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         pop;

    assign pop = pop_i && (cnt_q != 2'd0);

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = 2'd0;
        end else begin
            unique case ({push_i, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) e0_d = din_i;
                    else               e1_d = din_i;
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_d  = e1_q;
                    cnt_d = cnt_q - 2'd1;
                end
                2'b11: begin
                    // count unchanged; new entry lands behind whatever remains
                    if (cnt_q == 2'd1) begin
                        e0_d = din_i;
                    end else begin
                        e0_d = e1_q;
                        e1_d = din_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign valid_o = (cnt_q != 2'd0);
    assign head_o  = e0_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the PC, drives the ROM
// address and feeds decode through a 2-entry skid FIFO.
//   clk, rst        - clock, async active-high reset
//   fetch_en        - permits new fetches
//   redirect_valid  - branch/jump taken; redirect_pc is the byte target
//   bus (master)    - imem_pc/imem_instr ROM lookup, ifid_* decode handshake
//   halted          - high in HALT or END
module fetch_ctrl
    import mips_pkg::*;
#(
    parameter int                   PC_WIDTH   = PC_W,
    parameter int                   DATA_SIZE  = DATA_W,
    parameter int                   INSTR_NUM  = 15,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0,
    parameter logic [DATA_SIZE-1:0] HALT_INSTR = HALT_INSTR_DEF
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_en,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    fetch_ctrl_if.master        bus,
    output logic                halted
);

    localparam logic [PC_WIDTH-1:0] PC_ALIGN = ~PC_WIDTH'(1);

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                push, flush, deq, in_range;
    logic [1:0]          count;
    fetch_entry_t        din, head;

    // word index = pc_q >> 1; zero-extend so both sides are PC_WIDTH wide
    assign in_range = ({1'b0, pc_q[PC_WIDTH-1:1]} < PC_WIDTH'(INSTR_NUM));
    assign deq      = bus.ifid_valid && bus.ifid_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        if (redirect_valid) begin
            flush   = 1'b1;
            pc_d    = redirect_pc & PC_ALIGN;
            state_d = fetch_en ? RUN : IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (fetch_en) state_d = RUN;
                RUN: begin
                    if (!fetch_en) begin
                        state_d = IDLE;
                    end else if (!in_range) begin
                        state_d = END;
                    end else if (count != 2'd2 || deq) begin
                        push = 1'b1;
                        pc_d = pc_q + PC_WIDTH'(PC_STEP);
                        // the halt word itself still goes to decode
                        if (bus.imem_instr == HALT_INSTR) state_d = HALT;
                    end
                end
                default: ;  // HALT/END: only a redirect leaves
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC & PC_ALIGN;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign din.instr = bus.imem_instr;
    assign din.pc    = pc_q;

    fetch_skid_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (din),
        .pop_i   (deq),
        .flush_i (flush),
        .count_o (count),
        .valid_o (bus.ifid_valid),
        .head_o  (head)
    );

    assign bus.imem_pc    = pc_q;
    assign bus.ifid_instr = head.instr;
    assign bus.ifid_pc    = head.pc;
    assign halted         = (state_q == HALT) || (state_q == END);

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam int NW = 15;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_END = 3;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
    } ent_t;

    logic        clk, rst, fetch_en, redirect_valid, halted;
    logic [15:0] redirect_pc;
    logic [15:0] rom [NW];

    fetch_ctrl_if #(.PC_WIDTH(16), .DATA_SIZE(16)) bif ();

    fetch_ctrl #(.INSTR_NUM(NW)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bif),
        .halted         (halted)
    );

    // combinational ROM
    always_comb begin
        bif.imem_instr = 16'hDEAD;
        if (int'(bif.imem_pc[15:1]) < NW) bif.imem_instr = rom[int'(bif.imem_pc[15:1])];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   nvec, nerr;
    ent_t mq[$];
    int   mpc, mmode;
    logic [15:0] dut_last_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, "_valid"}, 32'(bif.ifid_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk({tag, "_hpc"},   32'(bif.ifid_pc),    32'(mq[0].pc));
            chk({tag, "_hins"},  32'(bif.ifid_instr), 32'(mq[0].instr));
        end
        chk({tag, "_impc"},   32'(bif.imem_pc), 32'(mpc));
        chk({tag, "_halted"}, 32'(halted),      32'(mmode >= M_HALT));
    endtask

    // Drive one cycle's inputs, advance the reference, then compare after the edge.
    task automatic tick(input logic fe, input logic rdy, input logic rv,
                        input logic [15:0] rpc, input string tag);
        logic deq, inr, fits;
        ent_t e;
        fetch_en = fe; bif.ifid_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        #1;
        if (bif.ifid_valid && rdy) dut_last_pc = bif.ifid_pc;
        deq = (mq.size() != 0) && rdy;
        if (rv) begin
            mq.delete();
            mpc   = int'(rpc) & 16'hFFFE;
            mmode = fe ? M_RUN : M_IDLE;
        end else begin
            inr  = (mpc / 2) < NW;
            fits = (mq.size() < 2) || deq;
            if (deq) void'(mq.pop_front());
            if (mmode == M_RUN && fe && inr && fits) begin
                e.instr = rom[mpc / 2];
                e.pc    = 16'(mpc);
                mq.push_back(e);
                mpc = (mpc + 2) % 65536;
                if (e.instr == 16'hFFFF) mmode = M_HALT;
            end else if (mmode == M_IDLE && fe) mmode = M_RUN;
            else if (mmode == M_RUN && !fe) mmode = M_IDLE;
            else if (mmode == M_RUN && !inr) mmode = M_END;
        end
        @(posedge clk);
        #1;
        cmp_model(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        bif.ifid_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete(); mpc = 0; mmode = M_IDLE;
        chk("rst_valid",  32'(bif.ifid_valid), 32'd0);
        chk("rst_instr",  32'(bif.ifid_instr), 32'd0);
        chk("rst_pc",     32'(bif.ifid_pc),    32'd0);
        chk("rst_impc",   32'(bif.imem_pc),    32'd0);
        chk("rst_halted", 32'(halted),         32'd0);
    endtask

    task automatic rom_default();
        for (int i = 0; i < NW; i++) rom[i] = 16'h2000 + 16'(i);
        for (int i = 0; i < 5; i++) rom[i] = 16'h1001 + 16'(i);
    endtask

    initial begin
        nvec = 0; nerr = 0; dut_last_pc = '0;
        rom_default();

        // straight-line flow
        do_reset();
        tick(1, 1, 0, 0, "sl0");
        chk("sl_first_not_yet", 32'(bif.ifid_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick(1, 1, 0, 0, "sl");
            chk("sl_valid", 32'(bif.ifid_valid), 32'd1);
            chk("sl_pc",    32'(bif.ifid_pc),    32'(2 * i));
            chk("sl_ins",   32'(bif.ifid_instr), 32'(16'h1001 + 16'(i)));
        end

        // backpressure
        do_reset();
        for (int i = 0; i < 5; i++) tick(1, 0, 0, 0, "bp");
        chk("bp_impc", 32'(bif.imem_pc),    32'd4);
        chk("bp_hpc",  32'(bif.ifid_pc),    32'd0);
        chk("bp_hins", 32'(bif.ifid_instr), 32'h1001);
        for (int i = 1; i < 3; i++) begin
            tick(1, 1, 0, 0, "bp_rel");
            chk("bp_rel_pc", 32'(bif.ifid_pc), 32'(2 * i));
        end

        // redirect with a full FIFO holding pc 6,8
        do_reset();
        for (int i = 0; i < 5; i++) tick(1, 1, 0, 0, "rd_fill");
        tick(1, 0, 0, 0, "rd_full");
        chk("rd_head6", 32'(bif.ifid_pc), 32'd6);
        tick(1, 0, 1, 16'h0015, "rd");
        chk("rd_valid", 32'(bif.ifid_valid), 32'd0);
        chk("rd_impc",  32'(bif.imem_pc),    32'h14);
        tick(1, 1, 0, 0, "rd_after");
        chk("rd_newhead", 32'(bif.ifid_pc), 32'h14);

        // halt word at index 3
        rom[3] = 16'hFFFF;
        do_reset();
        for (int i = 0; i < 10; i++) tick(1, 1, 0, 0, "ht");
        chk("ht_halted", 32'(halted),      32'd1);
        chk("ht_impc",   32'(bif.imem_pc), 32'd8);
        chk("ht_last",   32'(dut_last_pc), 32'd6);
        tick(1, 1, 1, 16'h0000, "ht_redir");
        chk("ht_resume", 32'(halted), 32'd0);
        tick(1, 1, 0, 0, "ht_go");
        chk("ht_go_impc", 32'(bif.imem_pc), 32'd2);
        rom_default();

        // end of ROM
        do_reset();
        for (int i = 0; i < 22; i++) tick(1, 1, 0, 0, "eor");
        chk("eor_last",   32'(dut_last_pc), 32'd28);
        chk("eor_halted", 32'(halted),      32'd1);
        chk("eor_impc",   32'(bif.imem_pc), 32'd30);
        tick(1, 1, 1, 16'h0040, "eor_oor");
        tick(1, 1, 0, 0, "eor_oor2");
        chk("eor_oor_end", 32'(halted), 32'd1);

        // asynchronous reset with two entries queued
        do_reset();
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 0, "ar");
        #3 rst = 1'b1;
        #1;
        chk("ar_valid",  32'(bif.ifid_valid), 32'd0);
        chk("ar_halted", 32'(halted),         32'd0);
        chk("ar_impc",   32'(bif.imem_pc),    32'd0);

        // randomized traffic against the reference
        for (int i = 0; i < NW; i++)
            rom[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic fe, rdy, rv;
            logic [15:0] tgt;
            fe  = ($urandom_range(0, 7) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            tgt = 16'($urandom_range(0, 40));
            tick(fe, rdy, rv, tgt, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
